// File: rtl/fetch_pipe.sv
// -----------------------------------------------------------------------------
// fetch_pipe
//
// Instruction-fetch stage plus IF/ID pipeline register for the rv32i core.
// Generates the fetch PC, drives a single-outstanding request/response
// instruction-memory port, and presents the returned instruction with its PC
// to decode. A one-entry skid buffer catches a response that lands while
// decode is stalled, so nothing is lost.
//
// Handshake: imem_req is a one-cycle strobe that launches a request to
// imem_addr. Exactly one imem_valid strobe answers each request, in order,
// at least one cycle later, with the instruction on imem_rdata. At most one
// request is ever outstanding; a new request is only launched in a cycle
// where nothing is outstanding or the outstanding response is being
// consumed in that same cycle.
//
// Ports:
//   clk                  clock, all state updates on posedge
//   rst                  asynchronous active-low reset
//   stall                hold IF/ID contents (decode cannot accept)
//   redirect_en          taken branch/jump: squash IF/ID and refetch
//   redirect_pc          redirect target, bits [1:0] ignored
//   imem_req             request strobe (combinational)
//   imem_addr            request address, meaningful while imem_req=1
//   imem_valid           response strobe
//   imem_rdata           response instruction
//   instruction_fetch_pp IF/ID instruction
//   pc_fetch_pp          IF/ID PC
//   valid_fetch_pp       IF/ID entry holds a real instruction
//   fsm_state            debug view of the fetch FSM state
// -----------------------------------------------------------------------------
module fetch_pipe #(
  parameter int                      DATA_WIDTH  = 32,
  parameter int                      INSTRUCTION = 32,
  parameter logic [DATA_WIDTH-1:0]   RESET_PC    = '0,
  parameter logic [INSTRUCTION-1:0]  NOP         = 'h13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect_en,
  input  logic [DATA_WIDTH-1:0]  redirect_pc,
  output logic                   imem_req,
  output logic [DATA_WIDTH-1:0]  imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTRUCTION-1:0] imem_rdata,
  output logic [INSTRUCTION-1:0] instruction_fetch_pp,
  output logic [DATA_WIDTH-1:0]  pc_fetch_pp,
  output logic                   valid_fetch_pp,
  output logic [1:0]             fsm_state
);

  // IDLE: nothing outstanding, skid empty.
  // WAIT: one request outstanding, its response is wanted.
  // DROP: one request outstanding, its response is stale (redirected away).
  // HELD: skid buffer full, nothing outstanding.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HELD = 2'd3
  } state_t;

  state_t                 state;
  logic [DATA_WIDTH-1:0]  fetch_pc;
  logic [DATA_WIDTH-1:0]  inflight_pc;
  logic [INSTRUCTION-1:0] skid_data;
  logic [DATA_WIDTH-1:0]  skid_pc;

  logic [DATA_WIDTH-1:0]  target;
  logic [DATA_WIDTH-1:0]  issue_addr;
  logic                   issue;
  logic                   load_ifid;
  logic [INSTRUCTION-1:0] load_data;
  logic [DATA_WIDTH-1:0]  load_pc;

  // Targets are word aligned; the low two bits of redirect_pc are dropped.
  assign target     = redirect_pc & ~DATA_WIDTH'(3);
  assign issue_addr = redirect_en ? target : fetch_pc;

  always_comb begin
    issue     = 1'b0;
    load_ifid = 1'b0;
    load_data = imem_rdata;
    load_pc   = inflight_pc;
    case (state)
      S_IDLE: issue = 1'b1;
      S_WAIT: begin
        // Consuming the response frees the port, so the next request can
        // go out in the same cycle: back-to-back one instruction per cycle.
        issue     = !redirect_en && imem_valid && !stall;
        load_ifid = issue;
      end
      S_HELD: begin
        issue     = !redirect_en && !stall;
        load_ifid = issue;
        load_data = skid_data;
        load_pc   = skid_pc;
      end
      default: issue = 1'b0;
    endcase
  end

  // The FSM sits in IDLE during reset; gate the strobe so no request
  // escapes until rst has been released.
  assign imem_req  = issue && rst;
  assign imem_addr = rst ? issue_addr : RESET_PC;
  assign fsm_state = state;

  // Fetch FSM, PC bookkeeping and skid buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      skid_data   <= NOP;
      skid_pc     <= '0;
    end else begin
      if (issue) begin
        inflight_pc <= issue_addr;
        fetch_pc    <= issue_addr + DATA_WIDTH'(4);
      end else if (redirect_en) begin
        fetch_pc <= target;
      end

      case (state)
        S_IDLE: state <= S_WAIT;
        S_WAIT: begin
          if (redirect_en) begin
            // Response in the same cycle is simply not consumed.
            state <= imem_valid ? S_IDLE : S_DROP;
          end else if (imem_valid && stall) begin
            skid_data <= imem_rdata;
            skid_pc   <= inflight_pc;
            state     <= S_HELD;
          end
        end
        S_DROP: begin
          if (imem_valid) state <= S_IDLE;
        end
        S_HELD: begin
          if (redirect_en) begin
            skid_data <= NOP;
            state     <= S_IDLE;
          end else if (!stall) begin
            skid_data <= NOP;
            state     <= S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // IF/ID register: flush beats stall, stall beats new data, otherwise a
  // bubble is inserted (PC held so decode sees a stable value).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instruction_fetch_pp <= NOP;
      pc_fetch_pp          <= '0;
      valid_fetch_pp       <= 1'b0;
    end else if (redirect_en) begin
      instruction_fetch_pp <= NOP;
      valid_fetch_pp       <= 1'b0;
    end else if (stall) begin
      instruction_fetch_pp <= instruction_fetch_pp;
      pc_fetch_pp          <= pc_fetch_pp;
      valid_fetch_pp       <= valid_fetch_pp;
    end else if (load_ifid) begin
      instruction_fetch_pp <= load_data;
      pc_fetch_pp          <= load_pc;
      valid_fetch_pp       <= 1'b1;
    end else begin
      instruction_fetch_pp <= NOP;
      valid_fetch_pp       <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_pipe.sv
// -----------------------------------------------------------------------------
// tb_fetch_pipe
//
// Bench for fetch_pipe. A small memory model answers each request after a
// programmable latency with a PC-derived word. Directed scenarios compare
// against hand-derived constants; the random scenario compares every cycle
// against a behavioural model that tracks "request outstanding / stale /
// instruction parked" as plain flags.
// -----------------------------------------------------------------------------
module tb_fetch_pipe;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_fetch_pp;
  logic [31:0] pc_fetch_pp;
  logic        valid_fetch_pp;
  logic [1:0]  fsm_state;

  always #5 clk = ~clk;

  fetch_pipe dut (
    .clk                  (clk),
    .rst                  (rst),
    .stall                (stall),
    .redirect_en          (redirect_en),
    .redirect_pc          (redirect_pc),
    .imem_req             (imem_req),
    .imem_addr            (imem_addr),
    .imem_valid           (imem_valid),
    .imem_rdata           (imem_rdata),
    .instruction_fetch_pp (instruction_fetch_pp),
    .pc_fetch_pp          (pc_fetch_pp),
    .valid_fetch_pp       (valid_fetch_pp),
    .fsm_state            (fsm_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- memory model ----------------
  int          mem_lat  = 1;
  logic        mem_busy = 1'b0;
  int          mem_cnt  = 0;
  logic [31:0] mem_pc   = '0;
  int          proto_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A00_0001;
  endfunction

  // ---------------- reference model ----------------
  logic        m_pend, m_stale, m_held;
  logic [31:0] m_held_pc, m_held_data, m_inflight, m_next;
  logic [31:0] m_instr, m_pc;
  logic        m_valid;
  logic        e_req;
  logic [31:0] e_addr;

  // Samples of the DUT for the cycle just run.
  logic        a_req;
  logic [31:0] a_addr;
  logic [31:0] a_instr, a_pc;
  logic        a_valid;

  task automatic model_reset();
    m_pend = 0; m_stale = 0; m_held = 0;
    m_held_pc = '0; m_held_data = NOP; m_inflight = RESET_PC;
    m_next = RESET_PC; m_instr = NOP; m_pc = '0; m_valid = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b0;
    stall = 0; redirect_en = 0; redirect_pc = '0;
    imem_valid = 0; imem_rdata = '0;
    mem_busy = 0; mem_cnt = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Runs one clock cycle. Called at posedge+1; inputs are driven, the
  // combinational request is sampled, the model advances, then the IF/ID
  // outputs are sampled at the following posedge+1.
  task automatic step_cycle(input logic st, input logic rd,
                            input logic [31:0] rpc, input logic spur);
    logic [31:0] tgt, d_data, d_pc;
    logic        mv, resp, fresh, dlv;
    stall = st; redirect_en = rd; redirect_pc = rpc;
    if (mem_busy && mem_cnt == 1) begin
      imem_valid = 1'b1;
      imem_rdata = mem_word(mem_pc);
      mem_busy   = 1'b0;
    end else begin
      imem_valid = spur && !mem_busy;
      imem_rdata = $urandom;
      if (mem_busy) mem_cnt--;
    end
    #1;
    a_req  = imem_req;
    a_addr = imem_addr;
    if (imem_req === 1'b1) begin
      if (mem_busy) proto_err++;
      mem_busy = 1'b1;
      mem_cnt  = mem_lat;
      mem_pc   = imem_addr;
    end

    // Model: a request is possible when nothing is outstanding and nothing
    // is parked, or when the wanted response is consumed right now.
    tgt   = {rpc[31:2], 2'b00};
    mv    = imem_valid;
    resp  = m_pend && mv;
    fresh = resp && !m_stale && !rd;
    if (!m_pend && !m_held) e_req = 1'b1;
    else if (m_pend)        e_req = fresh && !st;
    else                    e_req = !rd && !st;
    e_addr = rd ? tgt : m_next;

    dlv = 0; d_data = NOP; d_pc = '0;
    if (fresh && !st) begin dlv = 1; d_data = imem_rdata; d_pc = m_inflight; end
    if (m_held && !rd && !st) begin dlv = 1; d_data = m_held_data; d_pc = m_held_pc; end

    if (rd) begin m_instr = NOP; m_valid = 0; end
    else if (st) begin end
    else if (dlv) begin m_instr = d_data; m_pc = d_pc; m_valid = 1; end
    else begin m_instr = NOP; m_valid = 0; end

    if (m_held) m_held = !rd && st;
    else if (fresh && st) begin
      m_held = 1; m_held_data = imem_rdata; m_held_pc = m_inflight;
    end

    if (e_req) begin m_pend = 1; m_stale = 0; m_inflight = e_addr; end
    else if (resp) begin m_pend = 0; m_stale = 0; end
    else if (m_pend && rd) m_stale = 1;

    if (e_req) m_next = e_addr + 32'd4;
    else if (rd) m_next = tgt;

    @(posedge clk);
    #1;
    a_instr = instruction_fetch_pp;
    a_pc    = pc_fetch_pp;
    a_valid = valid_fetch_pp;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    stall = 0; redirect_en = 0; redirect_pc = '0;
    imem_valid = 0; imem_rdata = '0;
    @(posedge clk); #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); end
    checks++; if (instruction_fetch_pp !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", instruction_fetch_pp, NOP); end
    checks++; if (pc_fetch_pp !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", pc_fetch_pp); end
    checks++; if (valid_fetch_pp !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid_fetch_pp); end
  endtask

  task automatic test_sequential();
    do_reset(); mem_lat = 1;
    for (int k = 0; k < 6; k++) begin
      step_cycle(0, 0, '0, 0);
      checks++;
      if (a_req !== 1'b1 || a_addr !== 32'(4*k)) begin
        errors++; $display("FAIL seq_req k=%0d: got req=%b addr=%h expected req=1 addr=%h", k, a_req, a_addr, 32'(4*k));
      end
      checks++;
      if (k == 0) begin
        if (a_valid !== 1'b0) begin errors++; $display("FAIL seq_first_bubble: got valid=%b expected 0", a_valid); end
      end else if (a_valid !== 1'b1 || a_pc !== 32'(4*(k-1)) || a_instr !== mem_word(32'(4*(k-1)))) begin
        errors++; $display("FAIL seq_ifid k=%0d: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h",
                           k, a_valid, a_pc, a_instr, 32'(4*(k-1)), mem_word(32'(4*(k-1))));
      end
    end
  endtask

  task automatic test_stall_skid();
    do_reset(); mem_lat = 1;
    repeat (3) step_cycle(0, 0, '0, 0);
    for (int k = 0; k < 3; k++) begin
      step_cycle(1, 0, '0, 0);
      checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL stall_req k=%0d: got %b expected 0", k, a_req); end
      checks++;
      if (a_valid !== 1'b1 || a_pc !== 32'h4 || a_instr !== mem_word(32'h4)) begin
        errors++; $display("FAIL stall_hold k=%0d: got v=%b pc=%h expected v=1 pc=00000004", k, a_valid, a_pc);
      end
    end
    step_cycle(0, 0, '0, 0);
    checks++; if (a_req !== 1'b1 || a_addr !== 32'hC) begin errors++; $display("FAIL skid_req: got req=%b addr=%h expected req=1 addr=0000000c", a_req, a_addr); end
    checks++; if (a_valid !== 1'b1 || a_pc !== 32'h8 || a_instr !== mem_word(32'h8)) begin errors++; $display("FAIL skid_out: got v=%b pc=%h i=%h expected v=1 pc=00000008", a_valid, a_pc, a_instr); end
    step_cycle(0, 0, '0, 0);
    checks++; if (a_valid !== 1'b1 || a_pc !== 32'hC || a_instr !== mem_word(32'hC)) begin errors++; $display("FAIL skid_next: got v=%b pc=%h expected v=1 pc=0000000c", a_valid, a_pc); end
  endtask

  task automatic test_redirect_late();
    do_reset(); mem_lat = 1;
    repeat (3) step_cycle(0, 0, '0, 0);
    mem_lat = 3;
    step_cycle(0, 0, '0, 0);
    checks++; if (a_req !== 1'b1 || a_addr !== 32'hC) begin errors++; $display("FAIL late_req12: got req=%b addr=%h expected req=1 addr=0000000c", a_req, a_addr); end
    step_cycle(0, 1, 32'h100, 0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) step_cycle(0, 0, '0, 0);
      checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL late_noreq k=%0d: got %b expected 0", k, a_req); end
      checks++; if (a_valid !== 1'b0 || a_instr !== NOP) begin errors++; $display("FAIL late_flush k=%0d: got v=%b i=%h expected v=0 i=%h", k, a_valid, a_instr, NOP); end
    end
    step_cycle(0, 0, '0, 0);
    checks++; if (a_req !== 1'b1 || a_addr !== 32'h100) begin errors++; $display("FAIL late_target: got req=%b addr=%h expected req=1 addr=00000100", a_req, a_addr); end
    repeat (2) begin
      step_cycle(0, 0, '0, 0);
      checks++; if (a_valid !== 1'b0 || a_req !== 1'b0) begin errors++; $display("FAIL late_wait: got v=%b req=%b expected v=0 req=0", a_valid, a_req); end
    end
    step_cycle(0, 0, '0, 0);
    checks++; if (a_valid !== 1'b1 || a_pc !== 32'h100 || a_instr !== mem_word(32'h100)) begin errors++; $display("FAIL late_arrive: got v=%b pc=%h i=%h expected v=1 pc=00000100", a_valid, a_pc, a_instr); end
  endtask

  task automatic test_flush_beats_stall();
    do_reset(); mem_lat = 1;
    repeat (3) step_cycle(0, 0, '0, 0);
    step_cycle(1, 1, 32'h200, 0);
    checks++; if (a_req !== 1'b0) begin errors++; $display("FAIL fbs_req: got %b expected 0", a_req); end
    checks++; if (a_valid !== 1'b0 || a_instr !== NOP) begin errors++; $display("FAIL fbs_flush: got v=%b i=%h expected v=0 i=%h", a_valid, a_instr, NOP); end
    step_cycle(0, 0, '0, 0);
    checks++; if (a_req !== 1'b1 || a_addr !== 32'h200) begin errors++; $display("FAIL fbs_target: got req=%b addr=%h expected req=1 addr=00000200", a_req, a_addr); end
    step_cycle(0, 0, '0, 0);
    checks++; if (a_valid !== 1'b1 || a_pc !== 32'h200) begin errors++; $display("FAIL fbs_arrive: got v=%b pc=%h expected v=1 pc=00000200", a_valid, a_pc); end
  endtask

  task automatic test_align_wrap();
    do_reset(); mem_lat = 1;
    step_cycle(0, 1, 32'h0000_0203, 0);
    checks++; if (a_req !== 1'b1 || a_addr !== 32'h200) begin errors++; $display("FAIL align: got req=%b addr=%h expected req=1 addr=00000200", a_req, a_addr); end
    step_cycle(0, 1, 32'hFFFF_FFFC, 0);
    step_cycle(0, 0, '0, 0);
    checks++; if (a_req !== 1'b1 || a_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top: got req=%b addr=%h expected req=1 addr=fffffffc", a_req, a_addr); end
    step_cycle(0, 0, '0, 0);
    checks++; if (a_req !== 1'b1 || a_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero: got req=%b addr=%h expected req=1 addr=00000000", a_req, a_addr); end
    checks++; if (a_valid !== 1'b1 || a_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ifid: got v=%b pc=%h expected v=1 pc=fffffffc", a_valid, a_pc); end
    step_cycle(0, 0, '0, 0);
    checks++; if (a_valid !== 1'b1 || a_pc !== 32'h0 || a_instr !== mem_word(32'h0)) begin errors++; $display("FAIL wrap_ifid0: got v=%b pc=%h expected v=1 pc=00000000", a_valid, a_pc); end
  endtask

  task automatic test_async_reset();
    do_reset(); mem_lat = 1;
    repeat (3) step_cycle(0, 0, '0, 0);
    mem_lat = 3;
    step_cycle(0, 0, '0, 0);
    step_cycle(0, 0, '0, 0);
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== RESET_PC) begin errors++; $display("FAIL arst_port: got req=%b addr=%h expected req=0 addr=%h", imem_req, imem_addr, RESET_PC); end
    checks++; if (instruction_fetch_pp !== NOP || pc_fetch_pp !== 32'h0 || valid_fetch_pp !== 1'b0) begin
      errors++; $display("FAIL arst_ifid: got i=%h pc=%h v=%b expected i=%h pc=0 v=0", instruction_fetch_pp, pc_fetch_pp, valid_fetch_pp, NOP);
    end
    do_reset(); mem_lat = 1;
    step_cycle(0, 0, '0, 0);
    checks++; if (a_req !== 1'b1 || a_addr !== RESET_PC) begin errors++; $display("FAIL arst_restart: got req=%b addr=%h expected req=1 addr=%h", a_req, a_addr, RESET_PC); end
    step_cycle(0, 0, '0, 0);
    checks++; if (a_valid !== 1'b1 || a_pc !== RESET_PC) begin errors++; $display("FAIL arst_first: got v=%b pc=%h expected v=1 pc=%h", a_valid, a_pc, RESET_PC); end
  endtask

  task automatic test_random();
    logic st, rd, spur;
    logic [31:0] rpc;
    do_reset();
    proto_err = 0;
    for (int n = 0; n < 800; n++) begin
      mem_lat = $urandom_range(1, 3);
      st   = ($urandom_range(0, 9) < 3);
      rd   = ($urandom_range(0, 11) == 0);
      spur = ($urandom_range(0, 9) == 0);
      rpc  = $urandom;
      step_cycle(st, rd, rpc, spur);
      checks++; if (a_req !== e_req) begin errors++; $display("FAIL rnd_req n=%0d: got %b expected %b", n, a_req, e_req); end
      if (e_req) begin
        checks++; if (a_addr !== e_addr) begin errors++; $display("FAIL rnd_addr n=%0d: got %h expected %h", n, a_addr, e_addr); end
      end
      checks++; if (a_valid !== m_valid) begin errors++; $display("FAIL rnd_valid n=%0d: got %b expected %b", n, a_valid, m_valid); end
      checks++; if (a_instr !== m_instr) begin errors++; $display("FAIL rnd_instr n=%0d: got %h expected %h", n, a_instr, m_instr); end
      checks++; if (a_pc !== m_pc) begin errors++; $display("FAIL rnd_pc n=%0d: got %h expected %h", n, a_pc, m_pc); end
    end
    checks++; if (proto_err != 0) begin errors++; $display("FAIL rnd_outstanding: got %0d overlapping requests expected 0", proto_err); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_sequential();
    test_stall_skid();
    test_redirect_late();
    test_flush_beats_stall();
    test_align_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
